// File: rtl/mem_pkg.sv
// Shared types for the memory-port arbiter and lane aligner.
package mem_pkg;

   localparam logic [2:0] MOP_B  = 3'b000;
   localparam logic [2:0] MOP_H  = 3'b001;
   localparam logic [2:0] MOP_W  = 3'b010;
   localparam logic [2:0] MOP_BU = 3'b100;
   localparam logic [2:0] MOP_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      RESP,
      ERR
   } state_e;

   typedef enum logic {
      OWN_IFU,
      OWN_LSU
   } owner_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane legality, store shift/mask and load extract/extend.
module lsu_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  req_off_i,
   input  logic [2:0]  req_op_i,
   input  logic        req_wen_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  rsp_off_i,
   input  logic [2:0]  rsp_op_i,
   input  logic [31:0] rdata_i,
   output logic        legal_o,
   output logic [31:0] wdata_o,
   output logic [3:0]  wmask_o,
   output logic [31:0] rdata_o
);

   logic [31:0] b;

   always_comb begin
      legal_o = 1'b0;
      wmask_o = 4'b1111;
      case (req_op_i)
         MOP_B, MOP_BU: begin
            legal_o = !(req_wen_i && req_op_i == MOP_BU);
            wmask_o = 4'b0001 << req_off_i;
         end
         MOP_H, MOP_HU: begin
            legal_o = !req_off_i[0] && !(req_wen_i && req_op_i == MOP_HU);
            wmask_o = 4'b0011 << req_off_i;
         end
         MOP_W: begin
            legal_o = (req_off_i == 2'b00);
         end
         default: legal_o = 1'b0;
      endcase
      // Loads always read the whole word; lanes are picked on return.
      if (!req_wen_i) wmask_o = 4'b1111;
      wdata_o = wdata_i << {req_off_i, 3'b000};
   end

   always_comb begin
      b = rdata_i >> {rsp_off_i, 3'b000};
      case (rsp_op_i)
         MOP_B:   rdata_o = {{24{b[7]}}, b[7:0]};
         MOP_BU:  rdata_o = {24'h0, b[7:0]};
         MOP_H:   rdata_o = {{16{b[15]}}, b[15:0]};
         MOP_HU:  rdata_o = {16'h0, b[15:0]};
         default: rdata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one word-wide memory port between fetch and load/store.
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter bit LSU_PRIO = 1'b0,
   parameter int ADDR_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_rsp_valid,
   output logic [31:0]       ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_wen,
   input  logic [2:0]        lsu_memop,
   input  logic [31:0]       lsu_wdata,
   output logic              lsu_rsp_valid,
   output logic [31:0]       lsu_rdata,
   output logic              lsu_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wen,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_rsp_valid,
   input  logic [31:0]       mem_rdata
);

   state_e state_q, state_d;
   owner_e rr_q, rr_d;
   owner_e own_q, own_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic wen_q, wen_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0] wmask_q, wmask_d;
   logic [2:0] op_q, op_d;
   logic [1:0] off_q, off_d;
   logic ifu_rv_q, ifu_rv_d;
   logic lsu_rv_q, lsu_rv_d;
   logic err_q, err_d;
   logic [31:0] ifu_rd_q, ifu_rd_d;
   logic [31:0] lsu_rd_q, lsu_rd_d;

   logic gnt_ifu, gnt_lsu;
   logic al_legal;
   logic [31:0] al_wdata, al_rdata;
   logic [3:0] al_wmask;
   logic unused;

   // Fetch addresses are not checked; their low bits are simply dropped.
   assign unused = ^ifu_addr[1:0];

   lsu_lane_align u_align (
      .req_off_i (lsu_addr[1:0]),
      .req_op_i  (lsu_memop),
      .req_wen_i (lsu_wen),
      .wdata_i   (lsu_wdata),
      .rsp_off_i (off_q),
      .rsp_op_i  (op_q),
      .rdata_i   (mem_rdata),
      .legal_o   (al_legal),
      .wdata_o   (al_wdata),
      .wmask_o   (al_wmask),
      .rdata_o   (al_rdata)
   );

   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      own_d    = own_q;
      addr_d   = addr_q;
      wen_d    = wen_q;
      wdata_d  = wdata_q;
      wmask_d  = wmask_q;
      op_d     = op_q;
      off_d    = off_q;
      ifu_rv_d = 1'b0;
      lsu_rv_d = 1'b0;
      err_d    = 1'b0;
      ifu_rd_d = ifu_rd_q;
      lsu_rd_d = lsu_rd_q;
      gnt_ifu  = 1'b0;
      gnt_lsu  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ifu_req_valid && lsu_req_valid) begin
               if (LSU_PRIO || rr_q == OWN_IFU) gnt_lsu = 1'b1;
               else gnt_ifu = 1'b1;
            end else begin
               gnt_ifu = ifu_req_valid;
               gnt_lsu = lsu_req_valid;
            end
            if (gnt_ifu) begin
               own_d   = OWN_IFU;
               rr_d    = OWN_IFU;
               addr_d  = {ifu_addr[ADDR_W-1:2], 2'b00};
               wen_d   = 1'b0;
               wdata_d = 32'h0;
               wmask_d = 4'b1111;
               state_d = REQ;
            end
            if (gnt_lsu) begin
               own_d   = OWN_LSU;
               rr_d    = OWN_LSU;
               addr_d  = {lsu_addr[ADDR_W-1:2], 2'b00};
               wen_d   = lsu_wen;
               wdata_d = al_wdata;
               wmask_d = al_wmask;
               op_d    = lsu_memop;
               off_d   = lsu_addr[1:0];
               if (al_legal) begin
                  state_d = REQ;
               end else begin
                  // Error pulse is registered so it shows in the ERR cycle.
                  state_d  = ERR;
                  lsu_rv_d = 1'b1;
                  err_d    = 1'b1;
                  lsu_rd_d = 32'h0;
               end
            end
         end
         REQ: begin
            if (mem_req_ready) state_d = RESP;
         end
         RESP: begin
            if (mem_rsp_valid) begin
               state_d = IDLE;
               if (own_q == OWN_IFU) begin
                  ifu_rv_d = 1'b1;
                  ifu_rd_d = mem_rdata;
               end else begin
                  lsu_rv_d = 1'b1;
                  lsu_rd_d = wen_q ? 32'h0 : al_rdata;
               end
            end
         end
         ERR: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_q     <= OWN_LSU;
         own_q    <= OWN_IFU;
         addr_q   <= '0;
         wen_q    <= 1'b0;
         wdata_q  <= 32'h0;
         wmask_q  <= 4'h0;
         op_q     <= 3'b000;
         off_q    <= 2'b00;
         ifu_rv_q <= 1'b0;
         lsu_rv_q <= 1'b0;
         err_q    <= 1'b0;
         ifu_rd_q <= 32'h0;
         lsu_rd_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         rr_q     <= rr_d;
         own_q    <= own_d;
         addr_q   <= addr_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
         wmask_q  <= wmask_d;
         op_q     <= op_d;
         off_q    <= off_d;
         ifu_rv_q <= ifu_rv_d;
         lsu_rv_q <= lsu_rv_d;
         err_q    <= err_d;
         ifu_rd_q <= ifu_rd_d;
         lsu_rd_q <= lsu_rd_d;
      end
   end

   assign ifu_req_ready = gnt_ifu && !rst;
   assign lsu_req_ready = gnt_lsu && !rst;
   assign ifu_rsp_valid = ifu_rv_q;
   assign ifu_rdata     = ifu_rd_q;
   assign lsu_rsp_valid = lsu_rv_q;
   assign lsu_rdata     = lsu_rd_q;
   assign lsu_err       = err_q;
   assign mem_req_valid = (state_q == REQ);
   assign mem_addr      = addr_q;
   assign mem_wen       = wen_q;
   assign mem_wdata     = wdata_q;
   assign mem_wmask     = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter against a byte-level memory model.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        ifu_req_valid = 0, ifu_req_ready, ifu_rsp_valid;
   logic [31:0] ifu_addr = 0, ifu_rdata;
   logic        lsu_req_valid = 0, lsu_req_ready, lsu_wen = 0;
   logic [31:0] lsu_addr = 0, lsu_wdata = 0, lsu_rdata;
   logic [2:0]  lsu_memop = 0;
   logic        lsu_rsp_valid, lsu_err;
   logic        mem_req_valid, mem_req_ready = 0, mem_wen;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_rsp_valid = 0;
   logic [31:0] mem_rdata = 0;

   mem_port_arbiter #(.LSU_PRIO(1'b0), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
      .ifu_addr(ifu_addr), .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
      .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_memop(lsu_memop),
      .lsu_wdata(lsu_wdata), .lsu_rsp_valid(lsu_rsp_valid),
      .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
      .mem_rdata(mem_rdata)
   );

   // Second instance with LSU priority, driven by a simple tie pattern.
   logic        p_en = 0;
   logic        p_ifu_req_ready, p_ifu_rsp_valid, p_lsu_req_ready;
   logic        p_lsu_rsp_valid, p_lsu_err, p_mem_req_valid, p_mem_wen;
   logic [31:0] p_ifu_rdata, p_lsu_rdata, p_mem_addr, p_mem_wdata;
   logic [3:0]  p_mem_wmask;
   logic        p_mem_req_ready = 0, p_mem_rsp_valid = 0;
   logic [31:0] p_ifu_addr = 32'h80000000, p_lsu_addr = 32'h80000010;
   logic [2:0]  p_memop = 3'b010;
   logic        p_wen = 1'b0;
   logic [31:0] p_wdata = 32'h0, p_mem_rdata = 32'h0;

   mem_port_arbiter #(.LSU_PRIO(1'b1), .ADDR_W(32)) dut_p (
      .clk(clk), .rst(rst),
      .ifu_req_valid(p_en), .ifu_req_ready(p_ifu_req_ready),
      .ifu_addr(p_ifu_addr), .ifu_rsp_valid(p_ifu_rsp_valid),
      .ifu_rdata(p_ifu_rdata),
      .lsu_req_valid(p_en), .lsu_req_ready(p_lsu_req_ready),
      .lsu_addr(p_lsu_addr), .lsu_wen(p_wen), .lsu_memop(p_memop),
      .lsu_wdata(p_wdata), .lsu_rsp_valid(p_lsu_rsp_valid),
      .lsu_rdata(p_lsu_rdata), .lsu_err(p_lsu_err),
      .mem_req_valid(p_mem_req_valid), .mem_req_ready(p_mem_req_ready),
      .mem_addr(p_mem_addr), .mem_wen(p_mem_wen), .mem_wdata(p_mem_wdata),
      .mem_wmask(p_mem_wmask), .mem_rsp_valid(p_mem_rsp_valid),
      .mem_rdata(p_mem_rdata)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int p_gn = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endfunction

   function automatic void fail_now(string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s", nm);
   endfunction

   function automatic logic [7:0] init_b(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // emem: the memory wrapper's storage; mmem: the reference model's view.
   logic [7:0] emem [logic [31:0]];
   logic [7:0] mmem [logic [31:0]];

   function automatic logic [7:0] erd(input logic [31:0] a);
      return emem.exists(a) ? emem[a] : init_b(a);
   endfunction

   function automatic logic [7:0] mrd(input logic [31:0] a);
      return mmem.exists(a) ? mmem[a] : init_b(a);
   endfunction

   function automatic void set_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         emem[a + i] = w[8*i +: 8];
         mmem[a + i] = w[8*i +: 8];
      end
   endfunction

   bit zw = 1;
   bit stall = 0;
   int fdelay = -1;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin : responder
      logic pend;
      int cnt, d;
      logic [31:0] prd;
      pend = 0;
      cnt = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            pend = 0;
            mem_rsp_valid <= 1'b0;
            mem_req_ready <= 1'b0;
         end else begin
            mem_rsp_valid <= 1'b0;
            if (pend) begin
               cnt--;
               if (cnt == 0) begin
                  pend = 0;
                  mem_rsp_valid <= 1'b1;
                  mem_rdata <= prd;
               end
            end
            if (mem_req_valid && mem_req_ready) begin
               prd = $urandom;
               for (int i = 0; i < 4; i++) begin
                  if (mem_wen) begin
                     if (mem_wmask[i]) emem[mem_addr + i] = mem_wdata[8*i +: 8];
                  end else begin
                     prd[8*i +: 8] = erd(mem_addr + i);
                  end
               end
               d = (fdelay >= 0) ? fdelay : (zw ? 0 : int'($urandom_range(0, 3)));
               if (d == 0) begin
                  mem_rsp_valid <= 1'b1;
                  mem_rdata <= prd;
               end else begin
                  pend = 1;
                  cnt = d;
               end
            end
            mem_req_ready <= zw ? 1'b1 : (stall ? 1'b0 : ($urandom_range(0, 2) != 0));
         end
      end
   end

   initial begin : p_responder
      forever begin
         @(posedge clk);
         p_mem_req_ready <= !rst;
         p_mem_rsp_valid <= !rst && p_mem_req_valid && p_mem_req_ready;
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mreq_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          gcyc;
      int          lat;
   } rsp_t;

   mreq_t memq[$];
   rsp_t  ifuq[$];
   rsp_t  lsuq[$];
   bit    rr_lsu = 1;

   function automatic void model_ifu();
      logic [31:0] wa, v;
      wa = ifu_addr & ~32'h3;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = mrd(wa + i);
      memq.push_back('{wa, 1'b0, 32'h0, 4'hF});
      ifuq.push_back('{v, 1'b0, cyc, zw ? 3 : 0});
      rr_lsu = 0;
   endfunction

   function automatic void model_lsu();
      int n, m;
      bit legal;
      logic [31:0] wa, v;
      logic [1:0] o;
      case (lsu_memop)
         3'b000, 3'b100: n = 1;
         3'b001, 3'b101: n = 2;
         3'b010:         n = 4;
         default:        n = 0;
      endcase
      legal = (n != 0) && !(lsu_wen && lsu_memop[2]) && ((lsu_addr % n) == 0);
      rr_lsu = 1;
      if (!legal) begin
         lsuq.push_back('{32'h0, 1'b1, cyc, 1});
         return;
      end
      o = lsu_addr[1:0];
      wa = lsu_addr & ~32'h3;
      if (lsu_wen) begin
         for (int i = 0; i < n; i++) mmem[lsu_addr + i] = lsu_wdata[8*i +: 8];
         m = ((1 << n) - 1) << o;
         memq.push_back('{wa, 1'b1, lsu_wdata << (8 * o), m[3:0]});
         lsuq.push_back('{32'h0, 1'b0, cyc, zw ? 3 : 0});
      end else begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = mrd(lsu_addr + i);
         if (!lsu_memop[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
         if (!lsu_memop[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
         memq.push_back('{wa, 1'b0, 32'h0, 4'hF});
         lsuq.push_back('{v, 1'b0, cyc, zw ? 3 : 0});
      end
   endfunction

   initial begin : monitor
      rsp_t r;
      forever begin
         @(negedge clk);
         if (rst) begin
            memq.delete();
            ifuq.delete();
            lsuq.delete();
            rr_lsu = 1;
         end else begin
            if (mem_req_valid) begin
               if (memq.size() == 0) begin
                  fail_now($sformatf("mem_req unexpected addr %08h", mem_addr));
               end else begin
                  chk("mem_addr", mem_addr, memq[0].addr);
                  chk("mem_wen", 32'(mem_wen), 32'(memq[0].wen));
                  chk("mem_wmask", 32'(mem_wmask), 32'(memq[0].wmask));
                  if (memq[0].wen) chk("mem_wdata", mem_wdata, memq[0].wdata);
                  if (mem_req_ready) void'(memq.pop_front());
               end
            end
            if (ifu_rsp_valid) begin
               if (ifuq.size() == 0) begin
                  fail_now("ifu_rsp unexpected");
               end else begin
                  r = ifuq.pop_front();
                  chk("ifu_rdata", ifu_rdata, r.data);
                  if (r.lat != 0) chk("ifu_latency", cyc - r.gcyc, r.lat);
               end
            end
            if (lsu_rsp_valid) begin
               if (lsuq.size() == 0) begin
                  fail_now("lsu_rsp unexpected");
               end else begin
                  r = lsuq.pop_front();
                  chk("lsu_rdata", lsu_rdata, r.data);
                  chk("lsu_err", 32'(lsu_err), 32'(r.err));
                  if (r.lat != 0) chk("lsu_latency", cyc - r.gcyc, r.lat);
               end
            end
            if (ifu_req_ready && lsu_req_ready) fail_now("both granted");
            if (ifu_req_ready || lsu_req_ready) begin
               if (ifu_req_valid && lsu_req_valid)
                  chk("tie_winner_lsu", 32'(lsu_req_ready), rr_lsu ? 32'd0 : 32'd1);
               chk("grant_has_valid",
                   32'(ifu_req_ready ? ifu_req_valid : lsu_req_valid), 32'd1);
               if (lsu_req_ready) model_lsu();
               else model_ifu();
            end
            if (p_en && (p_ifu_req_ready || p_lsu_req_ready)) begin
               chk("prio_lsu_wins", 32'(p_lsu_req_ready), 32'd1);
               p_gn++;
            end
         end
      end
   end

   task automatic ifu_issue(input logic [31:0] a);
      ifu_addr = a;
      ifu_req_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (ifu_req_ready) begin
            @(posedge clk);
            #1;
            ifu_req_valid = 1'b0;
            return;
         end
      end
      fail_now("ifu_grant_timeout");
      ifu_req_valid = 1'b0;
   endtask

   task automatic lsu_issue(input logic [31:0] a, input logic [2:0] op,
                            input logic w, input logic [31:0] d);
      lsu_addr = a;
      lsu_memop = op;
      lsu_wen = w;
      lsu_wdata = d;
      lsu_req_valid = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (lsu_req_ready) begin
            @(posedge clk);
            #1;
            lsu_req_valid = 1'b0;
            return;
         end
      end
      fail_now("lsu_grant_timeout");
      lsu_req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (memq.size() == 0 && ifuq.size() == 0 && lsuq.size() == 0) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      fail_now("idle_timeout");
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ifu_req_ready"}, 32'(ifu_req_ready), 0);
      chk({tag, "_ifu_rsp_valid"}, 32'(ifu_rsp_valid), 0);
      chk({tag, "_ifu_rdata"}, ifu_rdata, 0);
      chk({tag, "_lsu_req_ready"}, 32'(lsu_req_ready), 0);
      chk({tag, "_lsu_rsp_valid"}, 32'(lsu_rsp_valid), 0);
      chk({tag, "_lsu_rdata"}, lsu_rdata, 0);
      chk({tag, "_lsu_err"}, 32'(lsu_err), 0);
      chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wen"}, 32'(mem_wen), 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_mem_wmask"}, 32'(mem_wmask), 0);
   endtask

   initial begin : stim
      logic [31:0] a;
      logic [2:0] op;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1;

      zw = 1;
      set_word(32'h80000004, 32'h00000413);
      ifu_issue(32'h80000004);
      wait_idle();
      set_word(32'h80000100, 32'h85001122);
      lsu_issue(32'h80000103, 3'b000, 1'b0, 32'h0);
      wait_idle();
      lsu_issue(32'h80000103, 3'b100, 1'b0, 32'h0);
      wait_idle();
      lsu_issue(32'h80000102, 3'b001, 1'b1, 32'h0000BEEF);
      wait_idle();
      lsu_issue(32'h80000100, 3'b010, 1'b0, 32'h0);
      wait_idle();
      lsu_issue(32'h80000006, 3'b010, 1'b0, 32'h0);
      wait_idle();
      lsu_issue(32'h80000006, 3'b101, 1'b1, 32'h0);
      wait_idle();

      p_en = 1;
      fork
         repeat (4) ifu_issue(32'h80000010);
         repeat (4) lsu_issue(32'h80000020, 3'b010, 1'b0, 32'h0);
      join
      p_en = 0;
      wait_idle();

      zw = 0;
      fork
         for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            a = 32'h80000000 + ($urandom_range(0, 15) << 2);
            if ($urandom_range(0, 7) == 0) a = a | $urandom_range(1, 3);
            ifu_issue(a);
         end
         for (int i = 0; i < 150; i++) begin
            logic [2:0] ops [5];
            ops = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                             : ops[$urandom_range(0, 4)];
            lsu_issue(32'h80000000 + $urandom_range(0, 63), op,
                      1'($urandom_range(0, 1)), $urandom);
         end
      join
      wait_idle();

      stall = 1;
      fdelay = 6;
      repeat (2) @(posedge clk);
      #1;
      ifu_issue(32'h80000040);
      repeat (4) begin
         @(negedge clk);
         chk("stall_req_held", 32'(mem_req_valid), 1);
         chk("stall_addr", mem_addr, 32'h80000040);
      end
      stall = 0;
      zw = 1;
      begin : wait_accept
         for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (memq.size() == 0) disable wait_accept;
         end
         fail_now("accept_timeout");
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      fdelay = -1;
      repeat (3) begin
         @(negedge clk);
         chk_zero("post_rst");
      end
      @(posedge clk);
      #1;
      fork
         ifu_issue(32'h80000044);
         lsu_issue(32'h80000048, 3'b010, 1'b0, 32'h0);
      join
      wait_idle();

      chk("prio_grant_count_ge3", 32'(p_gn >= 3), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
